// File: rtl/slice_serial_alu.sv
// rtl/slice_serial_alu.sv - slice-sequential 74181-equivalent ALU with start/done handshake
//
// Purpose:
//    Evaluates a WIDTH-bit 74181 function SLICE bits per clock, least
//    significant slice first, carrying between slices through a register.
//    Operands and controls are latched when a request is accepted; the
//    visible results and flags hold until the next operation completes.
//
// Ports:
//    clk     in   system clock, rising-edge
//    resetl  in   synchronous active-low reset
//    start   in   request, accepted only while busy=0
//    s       in   [3:0] 74181 function select
//    m       in   1 = logic, 0 = arithmetic
//    ci_n    in   active-low carry in
//    a, b    in   [WIDTH-1:0] operands
//    busy    out  operation in progress
//    done    out  one-cycle completion pulse
//    z       out  [WIDTH-1:0] result
//    co_n    out  active-low carry out of the MSB slice (1 in logic mode)
//    aeb     out  latched a==b
//    zero    out  z==0

module slice_serial_alu #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             resetl,
   input  logic             start,
   input  logic [3:0]       s,
   input  logic             m,
   input  logic             ci_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] z,
   output logic             co_n,
   output logic             aeb,
   output logic             zero
);

   localparam int NS = WIDTH / SLICE;
   localparam int CW = (NS > 1) ? $clog2(NS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NS - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] z_q, z_d;
   logic [3:0]       s_q, s_d;
   logic             m_q, m_d;
   logic             carry_q, carry_d;   // active-low, like ci_n
   logic             eq_q, eq_d;         // a==b captured at acceptance
   logic             done_q, done_d;
   logic             co_n_q, co_n_d;
   logic             aeb_q, aeb_d;
   logic             zero_q, zero_d;

   // Operands shift right one slice per cycle, so the live slice is always
   // at the bottom of a_q/b_q.
   logic [SLICE-1:0] f_sl;
   logic             c_out;
   logic [WIDTH-1:0] res_shift;

   always_comb begin
      logic c, x, y;
      c    = ~carry_q;
      x    = 1'b0;
      y    = 1'b0;
      f_sl = '0;
      for (int i = 0; i < SLICE; i++) begin
         // x: complement of generate, y: complement of propagate
         y = ~(a_q[i] | (s_q[0] & b_q[i]) | (s_q[1] & ~b_q[i]));
         x = ~((s_q[2] & a_q[i] & ~b_q[i]) | (s_q[3] & a_q[i] & b_q[i]));
         // logic mode masks the carry, which inverts the half-sum
         f_sl[i] = x ^ y ^ (m_q | c);
         c = ~x | (~y & c);
      end
      c_out = c;
   end

   // New slice enters at the top; after NS shifts the first slice sits at bit 0.
   assign res_shift = (res_q >> SLICE) | (WIDTH'(f_sl) << (WIDTH - SLICE));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      z_d     = z_q;
      s_d     = s_q;
      m_d     = m_q;
      carry_d = carry_q;
      eq_d    = eq_q;
      done_d  = 1'b0;
      co_n_d  = co_n_q;
      aeb_d   = aeb_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               s_d     = s;
               m_d     = m;
               carry_d = ci_n;
               eq_d    = (a == b);
               res_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> SLICE;
            b_d     = b_q >> SLICE;
            res_d   = res_shift;
            carry_d = ~c_out;
            if (cnt_q == LAST) begin
               z_d     = res_shift;
               co_n_d  = m_q | ~c_out;
               aeb_d   = eq_q;
               zero_d  = (res_shift == '0);
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetl) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         z_q     <= '0;
         s_q     <= '0;
         m_q     <= 1'b0;
         carry_q <= 1'b1;
         eq_q    <= 1'b0;
         done_q  <= 1'b0;
         co_n_q  <= 1'b1;
         aeb_q   <= 1'b0;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         z_q     <= z_d;
         s_q     <= s_d;
         m_q     <= m_d;
         carry_q <= carry_d;
         eq_q    <= eq_d;
         done_q  <= done_d;
         co_n_q  <= co_n_d;
         aeb_q   <= aeb_d;
         zero_q  <= zero_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = done_q;
   assign z    = z_q;
   assign co_n = co_n_q;
   assign aeb  = aeb_q;
   assign zero = zero_q;

endmodule
